sync_filter: RTL

- Multi-channel input synchroniser with a per-channel glitch filter: asynchronous inputs (pads, straps, cross-domain levels) pass through an N-stage resync chain and a consecutive-sample filter.
- Generalises the single-bit flop resync chain in width and mode, and adds a hold/enable and a change-strobe.
- Sits at the boundary of any clock domain consuming slow or noisy levels.
- Output is glitch-free and registered in clk.

---
 rtl/sync_filter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sync_filter.sv
// sync_filter
//   Multi-channel input synchroniser with a per-channel glitch filter.
//   Each channel of 'in' passes through a STAGES-deep resync chain. The last
//   stage (s) must differ from 'out' for FILTER consecutive enabled edges
//   before 'out' takes the new level. A single sample agreeing with 'out'
//   clears that channel's count, so no partial credit survives a bounce.
//   All outputs are registered in clk.
//
// Parameters
//   WIDTH     number of independent channels (>=1)
//   STAGES    resync flops per channel (>=2)
//   FILTER    consecutive differing samples needed to update out (>=1)
//   RESET_VAL value loaded into the sync chain and out during reset
//
// Ports
//   clk      in   rising-edge clock for every flop
//   rstb     in   synchronous active-low reset
//   in       in   [WIDTH] asynchronous channel inputs
//   en       in   filter enable; when low the counters clear and out holds
//   out      out  [WIDTH] filtered, synchronised levels
//   changed  out  [WIDTH] one-cycle strobe when out[i] toggles
//   busy     out  [WIDTH] filter counter for channel i is non-zero
//   rise     out  [WIDTH] out[i] updated 0->1 (only with SYNC_FILTER_EDGE_EN)
//   fall     out  [WIDTH] out[i] updated 1->0 (only with SYNC_FILTER_EDGE_EN)
//
// Optional feature macro: SYNC_FILTER_EDGE_EN adds the rise/fall outputs.

module sync_filter #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 2,
    parameter int               FILTER    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] busy
`ifdef SYNC_FILTER_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    // Counter must be able to hold FILTER-1; sized as $clog2(FILTER+1).
    localparam int             CW       = $clog2(FILTER + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    generate
        if (STAGES < 2 || FILTER < 1) begin : g_bad_params
            $error("sync_filter: STAGES must be >= 2 and FILTER must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]             out_q, out_d;
    logic [WIDTH-1:0]             changed_q, changed_d;
    logic [WIDTH-1:0]             busy_q, busy_d;
    logic [WIDTH-1:0]             s;
`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
`endif

    // Stage 0 takes the raw input; the last stage feeds the filter.
    assign s = sync_q[STAGES-1];

    always_comb begin
        sync_d    = {sync_q[STAGES-2:0], in};
        out_d     = out_q;
        cnt_d     = '0;
        changed_d = '0;
        busy_d    = '0;
`ifdef SYNC_FILTER_EDGE_EN
        rise_d    = '0;
        fall_d    = '0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            // With en low or s agreeing with out the count simply stays at 0.
            if (en && (s[i] != out_q[i])) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]     = s[i];
                    changed_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
            busy_d[i] = (cnt_d[i] != '0);
`ifdef SYNC_FILTER_EDGE_EN
            rise_d[i] = changed_d[i] & s[i];
            fall_d[i] = changed_d[i] & ~s[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync_q    <= {STAGES{RESET_VAL}};
            out_q     <= RESET_VAL;
            cnt_q     <= '0;
            changed_q <= '0;
            busy_q    <= '0;
`ifdef SYNC_FILTER_EDGE_EN
            rise_q    <= '0;
            fall_q    <= '0;
`endif
        end else begin
            sync_q    <= sync_d;
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
`ifdef SYNC_FILTER_EDGE_EN
            rise_q    <= rise_d;
            fall_q    <= fall_d;
`endif
        end
    end

    assign out     = out_q;
    assign changed = changed_q;
    assign busy    = busy_q;
`ifdef SYNC_FILTER_EDGE_EN
    assign rise    = rise_q;
    assign fall    = fall_q;
`endif

endmodule
